// File: rtl/uart_poll_scheduler.sv
// Poll scheduler for the RS485 UART channels of the frame builder: request/turnaround/listen
// per enabled channel, writing each response into the shared frame buffer.
module uart_poll_scheduler #(
    parameter int unsigned N_CH        = 5,
    parameter int unsigned RESP_BYTES  = 18,
    parameter logic [7:0]  REQ_CODE    = 8'hA0,
    parameter int unsigned GUARD_CYC   = 16,
    parameter int unsigned TIMEOUT_CYC = 8000
) (
    input  logic                                  clk80MHz,
    input  logic                                  rst,
    input  logic                                  pollStart,
    input  logic [N_CH-1:0]                       chEnable,
    output logic                                  txStart,
    output logic [7:0]                            txByte,
    input  logic                                  txBusy,
    input  logic                                  rxValid,
    input  logic [7:0]                            rxByte,
    output logic [$clog2(N_CH+1)-1:0]             chSel,
    output logic [N_CH-1:0]                       UART_dTX,
    output logic [N_CH-1:0]                       UART_dRX,
    output logic                                  wrEn,
    output logic [$clog2(N_CH*RESP_BYTES)-1:0]    wrAddr,
    output logic [7:0]                            wrData,
    output logic [N_CH-1:0]                       respOk,
    output logic [N_CH-1:0]                       respTimeout,
    output logic                                  busy,
    output logic                                  cycleDone
);
    localparam int unsigned AW = $clog2(N_CH*RESP_BYTES);
    localparam int unsigned IW = $clog2(N_CH+1);
    localparam int unsigned GW = $clog2(GUARD_CYC+1);
    localparam int unsigned TW = $clog2(TIMEOUT_CYC+1);
    localparam int unsigned CW = $clog2(RESP_BYTES+1);

    typedef enum logic [2:0] {
        IDLE, SCAN, DRIVE, SEND, TURN, LISTEN, NEXT, DONE
    } state_t;

    state_t            state;
    logic [N_CH-1:0]   en;
    logic [IW-1:0]     idx;
    logic [GW-1:0]     gcnt;
    logic [TW-1:0]     tcnt;
    logic [CW-1:0]     cnt;

    always_ff @(posedge clk80MHz) begin
        if (rst) begin
            state       <= IDLE;
            en          <= '0;
            idx         <= '0;
            gcnt        <= '0;
            tcnt        <= '0;
            cnt         <= '0;
            txStart     <= 1'b0;
            txByte      <= '0;
            chSel       <= '0;
            UART_dTX    <= '0;
            UART_dRX    <= '0;
            wrEn        <= 1'b0;
            wrAddr      <= '0;
            wrData      <= '0;
            respOk      <= '0;
            respTimeout <= '0;
            busy        <= 1'b0;
            cycleDone   <= 1'b0;
        end else begin
            txStart   <= 1'b0;
            wrEn      <= 1'b0;
            cycleDone <= 1'b0;
            unique case (state)
                IDLE: if (pollStart) begin
                    en          <= chEnable;
                    respOk      <= '0;
                    respTimeout <= '0;
                    busy        <= 1'b1;
                    idx         <= '0;
                    state       <= SCAN;
                end
                SCAN: begin
                    if (idx == IW'(N_CH)) begin
                        state <= DONE;
                    end else if (!en[idx]) begin
                        idx <= idx + IW'(1);
                    end else begin
                        chSel         <= idx + IW'(1);
                        UART_dTX[idx] <= 1'b1;
                        UART_dRX[idx] <= 1'b1;
                        gcnt          <= '0;
                        state         <= DRIVE;
                    end
                end
                DRIVE: begin
                    if (gcnt == GW'(GUARD_CYC-1)) begin
                        txStart <= 1'b1;
                        txByte  <= REQ_CODE + 8'(idx);
                        gcnt    <= '0;
                        state   <= SEND;
                    end else begin
                        gcnt <= gcnt + GW'(1);
                    end
                end
                // The TX core cannot raise txBusy in the txStart cycle, so that cycle is skipped.
                SEND: begin
                    if (gcnt == '0) begin
                        gcnt <= GW'(1);
                    end else if (!txBusy) begin
                        UART_dTX[idx] <= 1'b0;
                        gcnt          <= '0;
                        state         <= TURN;
                    end
                end
                // The cycle txBusy was seen low counts as the first turnaround cycle.
                TURN: begin
                    if (gcnt == GW'(GUARD_CYC-2)) begin
                        UART_dRX[idx] <= 1'b0;
                        tcnt          <= '0;
                        cnt           <= '0;
                        state         <= LISTEN;
                    end else begin
                        gcnt <= gcnt + GW'(1);
                    end
                end
                LISTEN: begin
                    if (rxValid) begin
                        wrEn   <= 1'b1;
                        wrAddr <= AW'(32'(idx) * RESP_BYTES + 32'(cnt));
                        wrData <= rxByte;
                        cnt    <= cnt + CW'(1);
                    end
                    // A final byte arriving on the timeout cycle takes priority.
                    if (rxValid && cnt == CW'(RESP_BYTES-1)) begin
                        respOk[idx] <= 1'b1;
                        state       <= NEXT;
                    end else if (tcnt == TW'(TIMEOUT_CYC-1)) begin
                        respTimeout[idx] <= 1'b1;
                        state            <= NEXT;
                    end else begin
                        tcnt <= tcnt + TW'(1);
                    end
                end
                NEXT: begin
                    chSel <= '0;
                    cnt   <= '0;
                    idx   <= idx + IW'(1);
                    state <= SCAN;
                end
                DONE: begin
                    busy      <= 1'b0;
                    cycleDone <= 1'b1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_poll_scheduler.sv
// Directed bench for uart_poll_scheduler: TX/RX responder models plus a transaction-level
// expectation model checked every cycle.
module tb_uart_poll_scheduler;
    localparam int unsigned N_CH    = 5;
    localparam int unsigned RB      = 18;
    localparam int unsigned GUARD   = 16;
    localparam int unsigned TIMEOUT = 8000;
    localparam logic [7:0]  REQ     = 8'hA0;

    logic       clk80MHz = 1'b0;
    logic       rst, pollStart, txBusy, rxValid;
    logic [4:0] chEnable;
    logic [7:0] rxByte, txByte, wrData;
    logic       txStart, wrEn, busy, cycleDone;
    logic [2:0] chSel;
    logic [4:0] UART_dTX, UART_dRX, respOk, respTimeout;
    logic [6:0] wrAddr;

    always #6 clk80MHz = ~clk80MHz;

    uart_poll_scheduler #(
        .N_CH(N_CH), .RESP_BYTES(RB), .REQ_CODE(REQ), .GUARD_CYC(GUARD), .TIMEOUT_CYC(TIMEOUT)
    ) dut (
        .clk80MHz(clk80MHz), .rst(rst), .pollStart(pollStart), .chEnable(chEnable),
        .txStart(txStart), .txByte(txByte), .txBusy(txBusy), .rxValid(rxValid), .rxByte(rxByte),
        .chSel(chSel), .UART_dTX(UART_dTX), .UART_dRX(UART_dRX), .wrEn(wrEn), .wrAddr(wrAddr),
        .wrData(wrData), .respOk(respOk), .respTimeout(respTimeout), .busy(busy),
        .cycleDone(cycleDone)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;

    // Expectation model: what a poll must produce, derived from the responder plan.
    logic [7:0] exp_tx[$];
    int         exp_wa[$];
    int         exp_wd[$];
    logic [4:0] exp_ok, exp_to;
    int         rcount[N_CH];
    int         rdelay, rspace;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: actual %0d, required %0d", name, act, req);
        end
    endtask

    task automatic set_model(input logic [4:0] en);
        int nb;
        exp_tx.delete(); exp_wa.delete(); exp_wd.delete();
        exp_ok = '0; exp_to = '0;
        for (int c = 0; c < N_CH; c++) begin
            if (en[c]) begin
                exp_tx.push_back(REQ + 8'(c));
                nb = 0;
                for (int i = 0; i < rcount[c] && i < RB; i++) begin
                    if (rdelay + i*rspace <= TIMEOUT-1) begin
                        exp_wa.push_back(c*RB + i);
                        exp_wd.push_back((i*10) % 256);
                        nb++;
                    end
                end
                exp_ok[c] = (nb == RB);
                exp_to[c] = (nb != RB);
            end
        end
    endtask

    initial forever begin
        @(posedge clk80MHz);
        cyc++;
    end

    // UART TX core: busy for 10 cycles after each txStart.
    initial begin
        txBusy = 1'b0;
        forever begin
            @(posedge clk80MHz); #1;
            if (txStart) begin
                txBusy = 1'b1;
                repeat (10) @(posedge clk80MHz);
                #1 txBusy = 1'b0;
            end
        end
    end

    // Responder: starts its reply relative to the dRX falling edge of the selected channel.
    initial begin
        logic [4:0] prev_drx;
        int ch, base, target;
        prev_drx = '0;
        rxValid = 1'b0;
        rxByte = '0;
        forever begin
            @(posedge clk80MHz); #1;
            ch = int'(chSel) - 1;
            if (ch >= 0 && !rst && prev_drx[ch] && !UART_dRX[ch]) begin
                base = cyc;
                for (int i = 0; i < rcount[ch]; i++) begin
                    target = base + rdelay + i*rspace;
                    while (cyc < target) begin
                        @(posedge clk80MHz); #1;
                    end
                    rxValid = 1'b1;
                    rxByte = 8'((i*10) % 256);
                    @(posedge clk80MHz); #1;
                    rxValid = 1'b0;
                end
            end
            prev_drx = UART_dRX;
        end
    end

    // Per-cycle compare against the expectation model and the timing rules.
    initial begin
        logic [4:0] p_dtx, p_drx, p_to;
        logic       p_txb, p_rxv, p_rst;
        int         rise_c, txfall_c, drxfall_c;
        p_dtx = '0; p_drx = '0; p_to = '0; p_txb = 0; p_rxv = 0; p_rst = 1;
        rise_c = 0; txfall_c = 0; drxfall_c = 0;
        forever begin
            @(negedge clk80MHz);
            if (busy) begin
                check("dtx_onehot", 64'($countones(UART_dTX) <= 1), 1);
                check("drx_onehot", 64'($countones(UART_dRX) <= 1), 1);
            end
            if ((UART_dTX & ~p_dtx) != '0) rise_c = cyc;
            if (p_txb && !txBusy) txfall_c = cyc;
            if (txStart) begin
                check("txstart_delay", cyc - rise_c, GUARD);
                if (exp_tx.size() == 0) check("tx_extra", 1, 0);
                else check("txbyte", txByte, exp_tx.pop_front());
            end
            if ((p_drx & ~UART_dRX) != '0 && !p_rst && UART_dTX == '0) begin
                drxfall_c = cyc;
                check("turn_delay", cyc - txfall_c, GUARD);
            end
            if ((respTimeout & ~p_to) != '0) check("listen_len", cyc - drxfall_c, TIMEOUT);
            if (wrEn) begin
                check("wr_latency", p_rxv, 1);
                if (exp_wa.size() == 0) check("wr_extra", 1, 0);
                else begin
                    check("wr_addr", wrAddr, exp_wa.pop_front());
                    check("wr_data", wrData, exp_wd.pop_front());
                end
            end
            if (cycleDone) begin
                check("done_respOk", respOk, exp_ok);
                check("done_respTimeout", respTimeout, exp_to);
            end
            p_dtx = UART_dTX; p_drx = UART_dRX; p_to = respTimeout;
            p_txb = txBusy; p_rxv = rxValid; p_rst = rst;
        end
    end

    task automatic pulse_poll(input logic [4:0] en);
        @(posedge clk80MHz); #1;
        pollStart = 1'b1;
        chEnable = en;
        @(posedge clk80MHz); #1;
        pollStart = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        bit seen = 0;
        for (int n = 0; n < 20000 && !seen; n++) begin
            @(negedge clk80MHz);
            if (cycleDone) seen = 1;
        end
        check({tag, "_done"}, seen, 1);
        @(negedge clk80MHz);
        check({tag, "_idle"}, busy, 0);
        check({tag, "_tx_left"}, exp_tx.size(), 0);
        check({tag, "_wr_left"}, exp_wa.size(), 0);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_ctl"}, {txStart, chSel, wrEn, busy, cycleDone}, 0);
        check({tag, "_pins"}, {UART_dTX, UART_dRX}, 0);
        check({tag, "_data"}, {txByte, wrAddr, wrData}, 0);
        check({tag, "_resp"}, {respOk, respTimeout}, 0);
    endtask

    task automatic plan(input int c0, input int c1, input int c2, input int c3, input int c4,
                        input int dly, input int spc);
        rcount[0] = c0; rcount[1] = c1; rcount[2] = c2; rcount[3] = c3; rcount[4] = c4;
        rdelay = dly; rspace = spc;
    endtask

    initial begin
        int  nbusy, ndone;
        logic [4:0] act;
        bit  seen;
        rst = 1'b1; pollStart = 1'b0; chEnable = '0;
        plan(0, 0, 0, 0, 0, 30, 5);
        repeat (3) @(posedge clk80MHz);
        #1 check_zero("reset");
        rst = 1'b0;

        // Channels 1 and 3 answer with 18 bytes.
        plan(18, 18, 18, 18, 18, 30, 5);
        set_model(5'b00101);
        check("pin_t1_ok", exp_ok, 5'b00101);
        check("pin_t1_nwr", exp_wa.size(), 36);
        check("pin_t1_addr", exp_wa[18], 36);
        check("pin_t1_data", exp_wd[17], 170);
        check("pin_t1_tx", {exp_tx[0], exp_tx[1]}, 16'hA0A2);
        pulse_poll(5'b00101);
        wait_done("t1");
        check("t1_respOk", respOk, 5'b00101);
        check("t1_respTimeout", respTimeout, 0);

        // Channel 2 silent: timeout.
        plan(18, 0, 18, 18, 18, 30, 5);
        set_model(5'b00010);
        check("pin_t2_to", exp_to, 5'b00010);
        pulse_poll(5'b00010);
        wait_done("t2");
        check("t2_respTimeout", respTimeout, 5'b00010);
        check("t2_respOk", respOk, 0);

        // Channel 5 over-long response: only 18 writes.
        plan(0, 0, 0, 0, 20, 30, 5);
        set_model(5'b10000);
        check("pin_t3_nwr", exp_wa.size(), 18);
        check("pin_t3_addr", exp_wa[0], 72);
        pulse_poll(5'b10000);
        wait_done("t3");
        check("t3_respOk", respOk, 5'b10000);

        // Nothing enabled.
        set_model(5'b00000);
        pulse_poll(5'b00000);
        nbusy = 0; ndone = 0; act = '0;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk80MHz);
            if (busy) nbusy++;
            if (cycleDone) ndone++;
            act |= UART_dTX | UART_dRX;
            if (!busy && nbusy > 0) break;
        end
        check("t4_busy_len", nbusy, N_CH + 2);
        check("t4_cycledone", ndone, 1);
        check("t4_no_pins", act, 0);

        // Repeat poll ignored, then reset during channel 4 turnaround.
        plan(18, 0, 0, 18, 0, 30, 5);
        set_model(5'b01001);
        pulse_poll(5'b01001);
        seen = 0;
        for (int n = 0; n < 2000 && !seen; n++) begin
            @(negedge clk80MHz);
            if (respOk[0]) seen = 1;
        end
        check("t5_ch1_ok", seen, 1);
        pulse_poll(5'b00010);
        @(negedge clk80MHz);
        check("t5_repeat_busy", busy, 1);
        check("t5_repeat_keep", respOk, 5'b00001);
        seen = 0;
        for (int n = 0; n < 2000 && !seen; n++) begin
            @(negedge clk80MHz);
            if (chSel == 3'd4 && UART_dTX == '0 && UART_dRX == 5'b01000) seen = 1;
        end
        check("t5_turn_seen", seen, 1);
        @(posedge clk80MHz); #1 rst = 1'b1;
        @(posedge clk80MHz); #1 rst = 1'b0;
        check_zero("t5_rst");
        check("t5_tx_sent", exp_tx.size(), 0);
        exp_wa.delete(); exp_wd.delete();
        plan(18, 0, 0, 0, 0, 30, 5);
        set_model(5'b00001);
        pulse_poll(5'b00001);
        wait_done("t5b");
        check("t5b_respOk", respOk, 5'b00001);
        check("t5b_respTimeout", respTimeout, 0);

        // Last byte on the timeout cycle: the byte wins.
        plan(18, 0, 0, 0, 0, TIMEOUT - 1 - 17*4, 4);
        set_model(5'b00001);
        check("pin_t6_ok", {exp_ok, exp_to}, 10'b00001_00000);
        check("pin_t6_nwr", exp_wa.size(), 18);
        pulse_poll(5'b00001);
        wait_done("t6");
        check("t6_respOk", respOk, 5'b00001);
        check("t6_respTimeout", respTimeout, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
